// File: rtl/prim_hold_pkg.sv
// Shared types and helpers for the output hold counter (prim_hold_ctr).
package prim_hold_pkg;

  typedef enum logic [0:0] {HoldIdle, HoldActive} hold_state_e;

  localparam int unsigned SwallowCntW = 16;

  // Counter width for a hold of the given length; never narrower than one bit.
  function automatic int unsigned hold_ctr_width(int unsigned cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/prim_hold_timer.sv
// Hold-window timer: restarts from zero on start_i/clear_i, stops at Cycles-1.
module prim_hold_timer
  import prim_hold_pkg::*;
#(
  parameter int unsigned Cycles = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  input  logic clear_i,
  output logic expired_o
);

  localparam int unsigned CtrW = hold_ctr_width(Cycles);
  localparam logic [CtrW-1:0] CtrMax = CtrW'(Cycles - 1);

  logic [CtrW-1:0] ctr_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i || start_i) begin
      ctr_q <= '0;
    end else if (ctr_q != CtrMax) begin
      ctr_q <= ctr_q + CtrW'(1);
    end
  end

  assign expired_o = (ctr_q == CtrMax);

endmodule

// File: rtl/prim_hold_ctr.sv
// Output hold counter: every output level lasts at least Cycles clocks.
// Define PRIM_HOLD_CTR_STATS_EN to add swallow_cnt_o (dropped-glitch statistics).
module prim_hold_ctr
  import prim_hold_pkg::*;
#(
  parameter int unsigned Cycles     = 4,
  parameter logic        ResetValue = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic enable_i,
  input  logic data_i,
  output logic out_o,
  output logic busy_o,
  output logic pending_o
`ifdef PRIM_HOLD_CTR_STATS_EN
  ,
  output logic [SwallowCntW-1:0] swallow_cnt_o
`endif
);

  if (Cycles < 2) begin : gen_cycles_check
    $error("prim_hold_ctr: Cycles must be at least 2");
  end

  hold_state_e state_q;
  logic        out_q;
  logic        change;
  logic        expired;
  logic        timer_start;
  logic        timer_clear;

  assign change = (data_i != out_q);

  // Restart on any accepted output change; park at zero while idle or bypassed.
  assign timer_start = enable_i && change &&
                       ((state_q == HoldIdle) || ((state_q == HoldActive) && expired));
  assign timer_clear = !enable_i || (state_q == HoldIdle);

  prim_hold_timer #(
    .Cycles (Cycles)
  ) u_timer (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .start_i   (timer_start),
    .clear_i   (timer_clear),
    .expired_o (expired)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= HoldIdle;
      out_q   <= ResetValue;
    end else if (!enable_i) begin
      state_q <= HoldIdle;
      out_q   <= data_i;
    end else begin
      unique case (state_q)
        HoldIdle: begin
          if (change) begin
            out_q   <= data_i;
            state_q <= HoldActive;
          end
        end
        HoldActive: begin
          if (expired) begin
            if (change) begin
              out_q <= data_i;
            end else begin
              state_q <= HoldIdle;
            end
          end
        end
        default: state_q <= HoldIdle;
      endcase
    end
  end

  assign out_o     = enable_i ? out_q : data_i;
  assign busy_o    = enable_i && (state_q == HoldActive);
  assign pending_o = busy_o && change;

`ifdef PRIM_HOLD_CTR_STATS_EN
  logic                   diff_seen_q;
  logic [SwallowCntW-1:0] swallow_cnt_q;
  logic                   swallow;

  // A hold that saw a differing request but expired with data back at out_q.
  assign swallow = busy_o && expired && !change && diff_seen_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      diff_seen_q   <= 1'b0;
      swallow_cnt_q <= '0;
    end else begin
      if (!busy_o || expired) begin
        diff_seen_q <= 1'b0;
      end else begin
        diff_seen_q <= diff_seen_q | change;
      end
      if (swallow && (swallow_cnt_q != '1)) begin
        swallow_cnt_q <= swallow_cnt_q + SwallowCntW'(1);
      end
    end
  end

  assign swallow_cnt_o = swallow_cnt_q;
`endif

endmodule

// File: tb/tb_prim_hold_ctr.sv
// Randomized and scripted bench for prim_hold_ctr against an age-based reference model.
module tb_prim_hold_ctr;

  localparam int unsigned Cycles     = 4;
  localparam logic        ResetValue = 1'b0;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic enable_i;
  logic data_i;
  logic out_o;
  logic busy_o;
  logic pending_o;
`ifdef PRIM_HOLD_CTR_STATS_EN
  logic [15:0] swallow_cnt_o;
`endif

  prim_hold_ctr #(
    .Cycles     (Cycles),
    .ResetValue (ResetValue)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .enable_i  (enable_i),
    .data_i    (data_i),
    .out_o     (out_o),
    .busy_o    (busy_o),
    .pending_o (pending_o)
`ifdef PRIM_HOLD_CTR_STATS_EN
    ,
    .swallow_cnt_o (swallow_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned cyc   = 0;

  // Reference model: output level plus the number of edges since it last changed.
  logic        m_out;
  int unsigned m_age;
  bit          m_dirty;
  int unsigned m_cnt;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (!rst_ni) begin
      m_out = ResetValue; m_age = Cycles; m_dirty = 0; m_cnt = 0;
    end else if (!enable_i) begin
      m_out = data_i; m_age = Cycles; m_dirty = 0;
    end else if (m_age >= Cycles - 1) begin
      // Hold finished (or never started): the sampled request wins.
      if (data_i != m_out) begin
        m_out = data_i; m_age = 0; m_dirty = 0;
      end else begin
        if (m_age == Cycles - 1 && m_dirty && m_cnt != 16'hFFFF) m_cnt++;
        m_dirty = 0;
        if (m_age < Cycles) m_age++;
      end
    end else begin
      if (data_i != m_out) m_dirty = 1;
      m_age++;
    end
  endtask

  // Check this cycle's outputs, then advance one clock edge.
  task automatic step(input logic r, input logic e, input logic d);
    logic exp_busy;
    rst_ni = r; enable_i = e; data_i = d;
    @(negedge clk_i);
    exp_busy = enable_i && (m_age < Cycles);
    check_eq("out_o", {15'd0, out_o}, {15'd0, enable_i ? m_out : data_i});
    check_eq("busy_o", {15'd0, busy_o}, {15'd0, exp_busy});
    check_eq("pending_o", {15'd0, pending_o}, {15'd0, exp_busy && (data_i != m_out)});
`ifdef PRIM_HOLD_CTR_STATS_EN
    check_eq("swallow_cnt_o", swallow_cnt_o, m_cnt[15:0]);
`endif
    @(posedge clk_i);
    model_edge();
    cyc++;
    #1;
  endtask

  initial begin
    logic d;
    rst_ni = 1'b0; enable_i = 1'b1; data_i = 1'b1;
    @(posedge clk_i);
    model_edge();
    #1;

    // Reset held with data_i=1: output stays at ResetValue.
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b1);
    // Single change, held.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1);
    // Glitch during hold.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1); step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b1);
    // Fast toggle.
    d = 1'b0;
    for (int i = 0; i < 20; i++) begin step(1'b1, 1'b1, d); d = ~d; end
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0);
    // Bypass abort mid-hold, then re-enable with matching data.
    step(1'b1, 1'b1, 1'b1); step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0);
    // Reset mid-hold, then release with data_i=1.
    step(1'b1, 1'b1, 1'b1); step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b1);

    // Randomized traffic: mostly enabled, occasional bypass and rare reset.
    d = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) < 40) d = ~d;
      step(($urandom_range(199) != 0), ($urandom_range(19) != 0), d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
